// File: rtl/tag_mem_pkg.sv
// Shared encodings for the tag memory arbiter: FSM states, bank selects,
// RorW codes and requester slot numbers.
package tag_mem_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd1,
        ST_PRECH   = 4'd2,
        ST_ACCESS  = 4'd4,
        ST_RECOVER = 4'd8
    } state_t;

    localparam logic [2:0] MEM_SEL_EPC = 3'd1;
    localparam logic [2:0] MEM_SEL_S1  = 3'd2;
    localparam logic [2:0] MEM_SEL_S2  = 3'd4;

    localparam logic [1:0] RORW_IDLE  = 2'b00;
    localparam logic [1:0] RORW_READ  = 2'b01;
    localparam logic [1:0] RORW_WRITE = 2'b10;

    localparam int REQ_SW = 0;
    localparam int REQ_EW = 1;
    localparam int REQ_RD = 2;
    localparam int REQ_N  = 3;

    // The EPC writer has a fixed bank; the sensor writer may only touch sensor banks.
    function automatic logic bank_legal(input logic [REQ_N-1:0] grant, input logic [2:0] bank);
        if (grant[REQ_EW])
            return 1'b1;
        if (bank == MEM_SEL_S1 || bank == MEM_SEL_S2)
            return 1'b1;
        return grant[REQ_RD] && (bank == MEM_SEL_EPC);
    endfunction

endpackage

// File: rtl/tag_mem_arb_prio.sv
// Fixed-priority requester select (sw > ew > rd) with a saturating starvation
// counter that lets a waiting read win after STARVE_LIMIT write grants.
module tag_mem_arb_prio
    import tag_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eval,
    input  logic             sw_req,
    input  logic             ew_req,
    input  logic             rd_req,
    output logic [REQ_N-1:0] grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic             starved;

    assign starved = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

    always_comb begin
        grant = '0;
        if (eval) begin
            if (rd_req && starved)
                grant[REQ_RD] = 1'b1;
            else if (sw_req)
                grant[REQ_SW] = 1'b1;
            else if (ew_req)
                grant[REQ_EW] = 1'b1;
            else if (rd_req)
                grant[REQ_RD] = 1'b1;
        end
    end

    // Only write grants that overtake a pending read count towards starvation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt_reg <= '0;
        else if (!rd_req || grant[REQ_RD])
            starve_cnt_reg <= '0;
        else if ((grant[REQ_SW] || grant[REQ_EW]) && !starved)
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end

endmodule

// File: rtl/tag_mem_arbiter.sv
// Arbitrates the tag memory macro between sensor write, EPC write and read
// paths, sequencing precharge/access/recover with fully registered outputs.
module tag_mem_arbiter
    import tag_mem_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_req,
    input  logic [2:0]        sw_bank,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    output logic              sw_done,
    input  logic              ew_req,
    input  logic [ADDR_W-1:0] ew_addr,
    input  logic [DATA_W-1:0] ew_data,
    output logic              ew_done,
    input  logic              rd_req,
    input  logic [2:0]        rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_done,
    output logic              err_bank,
    input  logic [DATA_W-1:0] mem_read_in,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic [2:0]        mem_sel,
    output logic              PC_B,
    output logic              WE,
    output logic              SE,
    output logic [1:0]        RorW,
    output logic              busy
);

    state_t             state_reg;
    logic [REQ_N-1:0]   grant;
    logic [REQ_N-1:0]   winner_reg;
    logic [DATA_W-1:0]  lat_data_reg;
    logic [2:0]         req_bank;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_data;

    tag_mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk   (clk),
        .reset (reset),
        .eval  (state_reg == ST_IDLE),
        .sw_req(sw_req),
        .ew_req(ew_req),
        .rd_req(rd_req),
        .grant (grant)
    );

    always_comb begin
        req_bank = sw_bank;
        req_addr = sw_addr;
        req_data = sw_data;
        if (grant[REQ_EW]) begin
            req_bank = MEM_SEL_EPC;
            req_addr = ew_addr;
            req_data = ew_data;
        end else if (grant[REQ_RD]) begin
            req_bank = rd_bank;
            req_addr = rd_addr;
            req_data = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            winner_reg   <= '0;
            lat_data_reg <= '0;
            rd_data      <= '0;
            sw_done      <= 1'b0;
            ew_done      <= 1'b0;
            rd_done      <= 1'b0;
            err_bank     <= 1'b0;
            mem_data_out <= '0;
            mem_address  <= '0;
            mem_sel      <= '0;
            PC_B         <= 1'b1;
            WE           <= 1'b0;
            SE           <= 1'b0;
            RorW         <= RORW_IDLE;
            busy         <= 1'b0;
        end else begin
            sw_done  <= 1'b0;
            ew_done  <= 1'b0;
            rd_done  <= 1'b0;
            err_bank <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (|grant) begin
                        winner_reg   <= grant;
                        lat_data_reg <= req_data;
                        busy         <= 1'b1;
                        if (bank_legal(grant, req_bank)) begin
                            state_reg   <= ST_PRECH;
                            PC_B        <= 1'b0;
                            mem_sel     <= req_bank;
                            mem_address <= req_addr;
                            RorW        <= grant[REQ_RD] ? RORW_READ : RORW_WRITE;
                        end else begin
                            // Bad bank: skip the macro entirely and report at once.
                            state_reg <= ST_RECOVER;
                            sw_done   <= grant[REQ_SW];
                            ew_done   <= grant[REQ_EW];
                            rd_done   <= grant[REQ_RD];
                            err_bank  <= 1'b1;
                        end
                    end
                end
                ST_PRECH: begin
                    PC_B <= 1'b1;
                    if (winner_reg[REQ_RD]) begin
                        SE <= 1'b1;
                    end else begin
                        WE           <= 1'b1;
                        mem_data_out <= lat_data_reg;
                    end
                    state_reg <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    WE   <= 1'b0;
                    SE   <= 1'b0;
                    RorW <= RORW_IDLE;
                    if (winner_reg[REQ_RD])
                        rd_data <= mem_read_in;
                    sw_done   <= winner_reg[REQ_SW];
                    ew_done   <= winner_reg[REQ_EW];
                    rd_done   <= winner_reg[REQ_RD];
                    state_reg <= ST_RECOVER;
                end
                ST_RECOVER: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_mem_arbiter.sv
// Directed and randomized checks of the tag memory arbiter against a
// word-level memory/arbitration model kept in the bench.
module tb_tag_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sw_req, ew_req, rd_req;
    logic [2:0]  sw_bank, rd_bank;
    logic [5:0]  sw_addr, ew_addr, rd_addr;
    logic [15:0] sw_data, ew_data;
    logic        sw_done, ew_done, rd_done, err_bank;
    logic [15:0] rd_data, mem_read_in, mem_data_out;
    logic [5:0]  mem_address;
    logic [2:0]  mem_sel;
    logic        PC_B, WE, SE, busy;
    logic [1:0]  RorW;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int pcb_low_cnt = 0;
    int we_cnt = 0;

    logic [15:0] macro_mem [0:2][0:63];
    logic [15:0] exp_mem   [0:2][0:63];
    logic [15:0] last_rd;
    int comp_q[$];
    int cyc_q[$];

    tag_mem_arbiter #(.ADDR_W(6), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .sw_req(sw_req), .sw_bank(sw_bank), .sw_addr(sw_addr), .sw_data(sw_data), .sw_done(sw_done),
        .ew_req(ew_req), .ew_addr(ew_addr), .ew_data(ew_data), .ew_done(ew_done),
        .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
        .err_bank(err_bank), .mem_read_in(mem_read_in), .mem_data_out(mem_data_out),
        .mem_address(mem_address), .mem_sel(mem_sel), .PC_B(PC_B), .WE(WE), .SE(SE),
        .RorW(RorW), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int bidx(input logic [2:0] b);
        case (b)
            3'd2:    return 1;
            3'd4:    return 2;
            default: return 0;
        endcase
    endfunction

    // Behavioural memory macro: writes on WE, combinational read at the selected word.
    always @(posedge clk) if (WE === 1'b1) macro_mem[bidx(mem_sel)][mem_address] <= mem_data_out;
    assign mem_read_in = macro_mem[bidx(mem_sel)][mem_address];

    always @(posedge clk) begin
        if (PC_B === 1'b0) pcb_low_cnt++;
        if (WE === 1'b1) we_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // who: 0 = sensor write, 1 = EPC write, 2 = read
    task automatic single(input int who, input logic [2:0] bank, input logic [5:0] addr, input logic [15:0] data);
        bit legal;
        bit seen;
        int lat;
        logic [2:0] dn;
        logic er;
        logic [15:0] rdv;
        logic [15:0] exp_rd;
        legal = (who == 1) ? 1'b1 :
                (who == 2) ? (bank == 3'd1 || bank == 3'd2 || bank == 3'd4) :
                             (bank == 3'd2 || bank == 3'd4);
        case (who)
            0: begin sw_bank = bank; sw_addr = addr; sw_data = data; sw_req = 1'b1; end
            1: begin ew_addr = addr; ew_data = data; ew_req = 1'b1; end
            default: begin rd_bank = bank; rd_addr = addr; rd_req = 1'b1; end
        endcase
        seen = 0; lat = 0; dn = '0; er = 1'b0; rdv = '0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            tick();
            if ((sw_done | ew_done | rd_done) === 1'b1) begin
                seen = 1; lat = k; dn = {rd_done, ew_done, sw_done}; er = err_bank; rdv = rd_data;
                sw_req = 1'b0; ew_req = 1'b0; rd_req = 1'b0;
            end
        end
        sw_req = 1'b0; ew_req = 1'b0; rd_req = 1'b0;
        chk("txn_done_seen", seen === 1'b1, seen, 1'b1);
        chk("txn_done_id", dn === 3'(1 << who), dn, 3'(1 << who));
        chk("txn_latency", lat === (legal ? 3 : 1), lat, (legal ? 3 : 1));
        chk("txn_err_bank", er === !legal, er, !legal);
        if (who == 2) begin
            exp_rd = legal ? exp_mem[bidx(bank)][addr] : last_rd;
            chk("txn_rd_data", rdv === exp_rd, rdv, exp_rd);
            last_rd = exp_rd;
        end else if (legal) begin
            exp_mem[bidx(bank)][addr] = data;
        end
        $display("txn who=%0d bank=%0d addr=%0d data=%h legal=%0d latency=%0d", who, bank, addr, data, legal, lat);
        tick();
    endtask

    // Runs several concurrent requesters; each drops on its done and optionally re-requests next cycle.
    task automatic run_multi(input int budget, input int want, input bit rearm);
        bit arm_sw, arm_ew, arm_rd;
        logic [15:0] exp_rd;
        arm_sw = 0; arm_ew = 0; arm_rd = 0;
        comp_q.delete();
        cyc_q.delete();
        for (int k = 1; k <= budget && comp_q.size() < want; k++) begin
            tick();
            if (arm_sw) sw_req = 1'b1;
            if (arm_ew) ew_req = 1'b1;
            if (arm_rd) rd_req = 1'b1;
            arm_sw = 0; arm_ew = 0; arm_rd = 0;
            if (sw_done === 1'b1) begin
                comp_q.push_back(0); cyc_q.push_back(k);
                exp_mem[bidx(sw_bank)][sw_addr] = sw_data;
                sw_req = 1'b0; arm_sw = rearm;
                $display("multi done=sw cycle=%0d", k);
            end
            if (ew_done === 1'b1) begin
                comp_q.push_back(1); cyc_q.push_back(k);
                exp_mem[0][ew_addr] = ew_data;
                ew_req = 1'b0; arm_ew = rearm;
                $display("multi done=ew cycle=%0d", k);
            end
            if (rd_done === 1'b1) begin
                comp_q.push_back(2); cyc_q.push_back(k);
                exp_rd = exp_mem[bidx(rd_bank)][rd_addr];
                chk("multi_rd_data", rd_data === exp_rd, rd_data, exp_rd);
                last_rd = exp_rd;
                rd_req = 1'b0; arm_rd = rearm;
                $display("multi done=rd cycle=%0d data=%h", k, rd_data);
            end
        end
        sw_req = 1'b0; ew_req = 1'b0; rd_req = 1'b0;
        tick();
        for (int k = 0; k < 8 && busy !== 1'b0; k++) tick();
    endtask

    initial begin
        int before_pcb;
        int before_we;
        logic [2:0] bank_tab [0:7];
        logic [2:0] rb;
        logic [15:0] rdat;
        int who;

        bank_tab[0] = 3'd1; bank_tab[1] = 3'd2; bank_tab[2] = 3'd4; bank_tab[3] = 3'd2;
        bank_tab[4] = 3'd4; bank_tab[5] = 3'd1; bank_tab[6] = 3'd3; bank_tab[7] = 3'd0;
        last_rd = 16'h0000;
        reset = 1'b1;
        sw_req = 1'b0; ew_req = 1'b0; rd_req = 1'b0;
        sw_bank = 3'd0; sw_addr = '0; sw_data = '0;
        ew_addr = '0; ew_data = '0; rd_bank = 3'd0; rd_addr = '0;
        tick(); tick();

        // Reset state
        chk("rst_pc_b", PC_B === 1'b1, PC_B, 1'b1);
        chk("rst_we", WE === 1'b0, WE, 1'b0);
        chk("rst_se", SE === 1'b0, SE, 1'b0);
        chk("rst_rorw", RorW === 2'b00, RorW, 2'b00);
        chk("rst_busy", busy === 1'b0, busy, 1'b0);
        chk("rst_rd_data", rd_data === 16'h0000, rd_data, 16'h0000);
        chk("rst_dones", {sw_done, ew_done, rd_done, err_bank} === 4'b0000, {sw_done, ew_done, rd_done, err_bank}, 4'b0000);
        reset = 1'b0;
        tick();

        // Sensor write, cycle by cycle
        sw_bank = 3'd2; sw_addr = 6'd5; sw_data = 16'hA55A; sw_req = 1'b1;
        tick();
        chk("sw_prech_pc_b", PC_B === 1'b0, PC_B, 1'b0);
        chk("sw_prech_rorw", RorW === 2'b10, RorW, 2'b10);
        chk("sw_prech_busy", busy === 1'b1, busy, 1'b1);
        chk("sw_prech_done", sw_done === 1'b0, sw_done, 1'b0);
        tick();
        chk("sw_acc_we", WE === 1'b1, WE, 1'b1);
        chk("sw_acc_pc_b", PC_B === 1'b1, PC_B, 1'b1);
        chk("sw_acc_sel", mem_sel === 3'd2, mem_sel, 3'd2);
        chk("sw_acc_addr", mem_address === 6'd5, mem_address, 6'd5);
        chk("sw_acc_data", mem_data_out === 16'hA55A, mem_data_out, 16'hA55A);
        chk("sw_acc_done", sw_done === 1'b0, sw_done, 1'b0);
        tick();
        chk("sw_rec_done", sw_done === 1'b1, sw_done, 1'b1);
        chk("sw_rec_we", WE === 1'b0, WE, 1'b0);
        sw_req = 1'b0;
        exp_mem[1][5] = 16'hA55A;
        tick();
        chk("sw_idle_done", sw_done === 1'b0, sw_done, 1'b0);
        chk("sw_idle_busy", busy === 1'b0, busy, 1'b0);
        $display("txn directed sw write bank=2 addr=5 data=a55a");

        // EPC word 3 = 1234, then read it cycle by cycle
        single(1, 3'd1, 6'd3, 16'h1234);
        rd_bank = 3'd1; rd_addr = 6'd3; rd_req = 1'b1;
        tick();
        chk("rd_prech_rorw", RorW === 2'b01, RorW, 2'b01);
        tick();
        chk("rd_acc_se", SE === 1'b1, SE, 1'b1);
        chk("rd_acc_we", WE === 1'b0, WE, 1'b0);
        tick();
        chk("rd_rec_done", rd_done === 1'b1, rd_done, 1'b1);
        chk("rd_rec_data", rd_data === 16'h1234, rd_data, 16'h1234);
        rd_req = 1'b0;
        last_rd = 16'h1234;
        for (int i = 0; i < 10; i++) tick();
        chk("rd_data_hold", rd_data === 16'h1234, rd_data, 16'h1234);
        $display("txn directed rd bank=1 addr=3 data=%h", rd_data);

        // Three simultaneous requests
        sw_bank = 3'd4; sw_addr = 6'd10; sw_data = 16'h1111;
        ew_addr = 6'd10; ew_data = 16'h2222;
        rd_bank = 3'd4; rd_addr = 6'd10;
        sw_req = 1'b1; ew_req = 1'b1; rd_req = 1'b1;
        run_multi(30, 3, 1'b0);
        chk("prio_count", comp_q.size() === 3, comp_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("prio_order", comp_q[i] === i, comp_q[i], i);
            chk("prio_cycle", cyc_q[i] === 3 + 4 * i, cyc_q[i], 3 + 4 * i);
        end

        // Starvation: writers re-request continuously, reader re-requests after each read
        sw_bank = 3'd2; sw_addr = 6'd11; sw_data = 16'h5A5A;
        ew_addr = 6'd12; ew_data = 16'h3C3C;
        rd_bank = 3'd2; rd_addr = 6'd11;
        sw_req = 1'b1; ew_req = 1'b1; rd_req = 1'b1;
        run_multi(80, 10, 1'b1);
        chk("starve_count", comp_q.size() === 10, comp_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk("starve_order", comp_q[i] === ((i == 4 || i == 9) ? 2 : 0), comp_q[i], ((i == 4 || i == 9) ? 2 : 0));
        end
        chk("starve_rd_cycle", cyc_q[4] === 19, cyc_q[4], 19);

        // Illegal banks never touch the macro
        before_pcb = pcb_low_cnt;
        before_we = we_cnt;
        sw_bank = 3'd1; sw_addr = 6'd7; sw_data = 16'hFFFF; sw_req = 1'b1;
        tick();
        chk("bad_sw_done", sw_done === 1'b1, sw_done, 1'b1);
        chk("bad_sw_err", err_bank === 1'b1, err_bank, 1'b1);
        chk("bad_sw_pc_b", PC_B === 1'b1, PC_B, 1'b1);
        chk("bad_sw_busy", busy === 1'b1, busy, 1'b1);
        sw_req = 1'b0;
        tick();
        chk("bad_sw_err_clear", err_bank === 1'b0, err_bank, 1'b0);
        chk("bad_sw_idle", busy === 1'b0, busy, 1'b0);
        chk("bad_sw_no_prech", pcb_low_cnt === before_pcb, pcb_low_cnt, before_pcb);
        chk("bad_sw_no_we", we_cnt === before_we, we_cnt, before_we);
        $display("txn directed sw illegal bank=1");
        single(2, 3'd3, 6'd0, 16'h0000);

        // Reset in ACCESS of an EPC write
        ew_addr = 6'd20; ew_data = 16'hDEAD; ew_req = 1'b1;
        tick(); tick();
        chk("rst_mid_we_before", WE === 1'b1, WE, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_we", WE === 1'b0, WE, 1'b0);
        chk("rst_mid_pc_b", PC_B === 1'b1, PC_B, 1'b1);
        chk("rst_mid_busy", busy === 1'b0, busy, 1'b0);
        ew_req = 1'b0;
        tick();
        chk("rst_mid_no_done", ew_done === 1'b0, ew_done, 1'b0);
        reset = 1'b0;
        tick();
        chk("rst_mid_no_done2", ew_done === 1'b0, ew_done, 1'b0);
        $display("txn directed ew aborted by reset");
        single(1, 3'd1, 6'd20, 16'hBEEF);
        single(2, 3'd1, 6'd20, 16'h0000);

        // Random phase: fill a small window of every bank, then mix traffic
        for (int a = 0; a < 8; a++) begin
            single(1, 3'd1, 6'(a), 16'($urandom));
            single(0, 3'd2, 6'(a), 16'($urandom));
            single(0, 3'd4, 6'(a), 16'($urandom));
        end
        for (int t = 0; t < 30; t++) begin
            who = int'($urandom_range(0, 2));
            rb = (who == 1) ? 3'd1 : bank_tab[$urandom_range(0, 7)];
            rdat = 16'($urandom);
            single(who, rb, 6'($urandom_range(0, 7)), rdat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tag_mem_arbiter.md
Name: tag_mem_arbiter

Overview:
Shares the single tag memory macro (EPC, sensor-1 and sensor-2 banks) between three requesters: the sensor/ADC write path, the EPC write path and the read/backscatter path. It grants one requester at a time and runs the precharge/access/recover sequence on PC_B, WE and SE. It returns read data and a one-cycle done per transaction, so requesters never drive the macro directly.

Parameters:
ADDR_W, 6, memory word address width
DATA_W, 16, memory word width
STARVE_LIMIT, 4, number of consecutive write grants while rd_req is pending before the read path is forced to win

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sw_req  in  1  sensor write request, level, held until sw_done
sw_bank  in  3  target bank: 3'd2 = sensor1, 3'd4 = sensor2
sw_addr  in  ADDR_W  sensor write address
sw_data  in  DATA_W  sensor write data ({time_stamp, adc})
sw_done  out  1  sensor write complete, one-cycle pulse
ew_req  in  1  EPC write request, level
ew_addr  in  ADDR_W  EPC write address; bank is fixed to 3'd1
ew_data  in  DATA_W  EPC write data
ew_done  out  1  EPC write complete pulse
rd_req  in  1  read request, level
rd_bank  in  3  3'd1 EPC, 3'd2 sensor1, 3'd4 sensor2
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read word, held until the next read completes
rd_done  out  1  read complete pulse
err_bank  out  1  pulse: granted request had an illegal bank code
mem_read_in  in  DATA_W  macro read data
mem_data_out  out  DATA_W  macro write data
mem_address  out  ADDR_W  macro word line address
mem_sel  out  3  one-hot bank select
PC_B  out  1  precharge, active low
WE  out  1  write enable
SE  out  1  sense enable
RorW  out  2  2'b01 read, 2'b10 write, 2'b00 idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: PC_B=1; all other outputs 0. State=IDLE, starve_cnt=0.
- All outputs are registered.
- States are one-hot: IDLE=4'd1, PRECH=4'd2, ACCESS=4'd4, RECOVER=4'd8.
- IDLE: sample requests and pick a winner.
  - Fixed priority: sw > ew > rd.
  - Exception: if starve_cnt == STARVE_LIMIT and rd_req=1, rd wins.
  - Latch winner, bank, address and data into internal registers.
  - Go to PRECH, or go to RECOVER if the bank code is illegal.
  - No request: stay in IDLE.
- PRECH: PC_B=0. mem_sel and mem_address driven from the latch. RorW set. Next state ACCESS.
- ACCESS: PC_B=1.
  - Write: WE=1, mem_data_out=latched data.
  - Read: SE=1; rd_data captured from mem_read_in on the exiting edge.
  - Next state RECOVER.
- RECOVER: WE=0, SE=0, RorW=0. The winner's done=1 for this cycle. Next state IDLE. mem_sel and mem_address hold their values.
- Latency: request seen in IDLE at cycle N gives PRECH N+1, ACCESS N+2, done N+3, IDLE N+4. Minimum 4 cycles per transaction.
- Requesters must drop req on the edge at which they sample done=1. A req still high in IDLE is treated as a new request.
- Latched address and data are immune to requester changes after grant.
- Starvation counter:
  - Increments on each sw/ew grant while rd_req=1, saturating at STARVE_LIMIT.
  - Clears on an rd grant or whenever rd_req=0.
- Illegal bank (sw_bank not 2 or 4; rd_bank not 1, 2 or 4): no PC_B/WE/SE activity. RECOVER gives done together with err_bank=1. rd_data is unchanged.
- Simultaneous requests arriving mid-transaction wait; arbitration happens only in IDLE.
- Reset mid-operation: outputs return to reset values immediately and asynchronously. The transaction is dropped with no done pulse; the requester must re-request.

Decomposition:
- Package tag_mem_pkg holds:
  - state encodings;
  - bank codes MEM_SEL_EPC=3'd1, MEM_SEL_S1=3'd2, MEM_SEL_S2=3'd4;
  - RorW codes RORW_IDLE/READ/WRITE;
  - requester IDs.
- One sub-module, tag_mem_arb_prio, contains the priority select plus starve_cnt. It outputs a one-hot grant and is evaluated only in IDLE.

Test Plan:
- sw_req=1, sw_bank=3'd2, sw_addr=6'd5, sw_data=16'hA55A → PC_B=0 at N+1; WE=1, mem_sel=3'd2, mem_address=5, mem_data_out=16'hA55A at N+2; sw_done=1 at N+3 only.
- rd_req=1, rd_bank=3'd1, rd_addr=6'd3, mem_read_in=16'h1234 during ACCESS → SE=1 at N+2; rd_data=16'h1234 with rd_done at N+3; rd_data still 16'h1234 after 10 idle cycles.
- sw_req, ew_req and rd_req rise together, each dropped on its done → completion order sw, ew, rd; dones at N+3, N+7, N+11.
- sw_req and ew_req re-asserted continuously with rd_req held, STARVE_LIMIT=4 → rd granted after exactly 4 write grants; starve_cnt returns to 0.
- sw_bank=3'd1 → no PC_B low, no WE; sw_done=1 and err_bank=1 at N+1 (the RECOVER cycle); the macro is never accessed.
- reset pulsed while in ACCESS of an ew write → WE=0, PC_B=1, busy=0 immediately, no ew_done; re-request completes normally with ew_done at N+3.
